reg_dump: RTL and testbench
===========================

# reg_dump

Debug readout engine that walks the 16-entry CPU register file through one read port and shifts every word out serially, MSB first, on a single-wire data output with a qualifying valid/strobe. It sits beside the register file, sharing its combinational read-select/read-value interface, and is triggered by the debug/test logic. It is the read-side counterpart of the register file's write port.

## Interface
- `REG_COUNT`, 16: number of registers dumped, indices 0..REG_COUNT-1; legal 1..16.
- `CLK_DIV`, 4: clock cycles per serial bit; legal ≥1.
- `clk` in 1: the single clock; all logic on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: one-cycle request to begin a dump; ignored unless IDLE.
- `abort` in 1: cancel the dump in progress.
- `r_sel` out 4: register-file read select.
- `r_value` in 32: register-file combinational read value for `r_sel`.
- `sdo` out 1: serial data, MSB first.
- `sdo_valid` out 1: high on every cycle that `sdo` carries a frame bit.
- `sdo_stb` out 1: one-cycle pulse on the first cycle of each bit.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse after the last bit of a completed dump.

## Operation
- States: IDLE, LOAD, SHIFT, DONE; CKLOAD and CKSHIFT exist only with the checksum option.
- IDLE: `start`=1 → LOAD, word index cleared to 0.
- LOAD, one cycle: `r_sel`=index; at the cycle's end `r_value` is captured into the 32-bit shift register → SHIFT.
- SHIFT: `sdo`=shift[31]. After CLK_DIV cycles the register shifts left by 1. After 32 bits:
  - index < REG_COUNT-1 → index+1, LOAD.
  - Otherwise → CKLOAD if enabled, else DONE.
- DONE, one cycle: `done`=1 → IDLE.
- Each word is sampled at its own LOAD cycle. Writes to the register file during a dump are visible to words not yet loaded. No atomic snapshot is taken.
- `r_sel` holds the current index in all states; it is 0 in IDLE.
- `abort`=1 in any non-IDLE state → IDLE on the next edge. No `done` pulse; `sdo_valid` is low from that edge onward. `abort` has priority over every other transition.
- `start` while busy has no effect. `start` and `abort` together in IDLE: `abort` wins and the block stays IDLE.

## Timing
- Reset values: `r_sel`=0, `sdo`=0, `sdo_valid`=0, `sdo_stb`=0, `busy`=0, `done`=0. Reset clears state, index, shift register, bit counter and divider.
- Reset asserted mid-dump: outputs return to reset values immediately. No `done` pulse.
- `start` sampled at edge E: `busy`=1 from E. LOAD occupies cycle E..E+1. The first bit (`sdo_valid`=1, `sdo_stb`=1) starts at E+1.
- Each word takes 1 + 32·CLK_DIV cycles.
- Full dump without checksum takes REG_COUNT·(1+32·CLK_DIV) cycles. `done` is high in the following cycle, and `busy` drops one cycle after that.
- `sdo_valid` is low during LOAD and CKLOAD cycles. This one-cycle gap delimits words.
- CLK_DIV=1: one bit per cycle, and `sdo_stb` stays high throughout SHIFT.

## Configuration
- `REG_DUMP_CKSUM_EN` defined:
  - A 32-bit accumulator is cleared at `start` and XORs each word at its LOAD capture.
  - After the last register: CKLOAD (one cycle, accumulator → shift register), then CKSHIFT (32 bits, identical timing to SHIFT), then DONE.
  - Total dump time adds 1+32·CLK_DIV cycles.
- Not defined: no accumulator, no CK states; the last word goes directly to DONE.

## Structure
- Shared package `reg_dump_pkg` holds:
  - the state enumeration;
  - the word width constant, 32;
  - the bit count constant, 32.
- Sub-module `bit_timer`: a divide-by-CLK_DIV counter that produces the `sdo_stb` and bit-end strobes. It is enabled only in SHIFT/CKSHIFT and cleared otherwise.

## Test plan
- Reset, then registers 1..15 = 0x1000_0000+i (reg0 = 0), CLK_DIV=1, `start` → 16 words of 32 bits, MSB first, in order 0..15 with a one-cycle gap between words; `done` at cycle 16·33; `busy` falls one cycle later.
- CLK_DIV=4, reg0=0xA5A5_A5A5 → each bit is held 4 cycles with a single `sdo_stb`; the first bit follows `start` by 2 cycles.
- Checksum build, registers = i·0x0101_0101 → a 17th word equal to the XOR of all 16 values, then `done`.
- Write reg5=0xDEAD_BEEF during word 3 → word 5 reads 0xDEAD_BEEF.
- `abort` mid-word 7, plus a `start` during SHIFT → IDLE on the next edge, `sdo_valid`=0, no `done`, and the mid-dump `start` is ignored.
- Assert `rst_n`=0 asynchronously mid-bit → all outputs are 0 before the next clock edge; a fresh `start` dumps from reg0.

Source files
------------

// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register dump engine: state encoding and word/bit sizing.
// The checksum states are only reachable when REG_DUMP_CKSUM_EN is defined.
package reg_dump_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned BIT_COUNT = 32;
    localparam int unsigned BIT_CNT_W = $clog2(BIT_COUNT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE,
        ST_CKLOAD,
        ST_CKSHIFT
    } state_t;

endpackage

// File: rtl/reg_dump_bit_timer.sv
// Divide-by-CLK_DIV bit timer: stb marks the first cycle of a serial bit, bit_end its last.
// Held at zero whenever en is low so every word starts on a fresh bit boundary.
module bit_timer #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic stb,
    output logic bit_end
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        div_d = '0;
        if (en && (div_q != DIV_LAST)) begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign stb     = en && (div_q == '0);
    assign bit_end = en && (div_q == DIV_LAST);

endmodule

// File: rtl/reg_dump.sv
// Serial register-file dump engine: loads each word through the read port and shifts it out MSB first.
// Optional trailing XOR checksum word when REG_DUMP_CKSUM_EN is defined.
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int unsigned REG_COUNT = 16,
    parameter int unsigned CLK_DIV   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [3:0]        r_sel,
    input  logic [WORD_W-1:0] r_value,
    output logic              sdo,
    output logic              sdo_valid,
    output logic              sdo_stb,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0]           LAST_IDX = 4'(REG_COUNT - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BIT_COUNT - 1);

    state_t                 state_q, state_d;
    logic [3:0]             idx_q, idx_d;
    logic [WORD_W-1:0]      shift_q, shift_d;
    logic [BIT_CNT_W-1:0]   bit_q, bit_d;
    logic                   shifting;
    logic                   bit_end;
`ifdef REG_DUMP_CKSUM_EN
    logic [WORD_W-1:0]      cksum_q, cksum_d;
`endif

    assign shifting = (state_q == ST_SHIFT) || (state_q == ST_CKSHIFT);

    bit_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_bit_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (shifting),
        .stb    (sdo_stb),
        .bit_end(bit_end)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        bit_d   = bit_q;
`ifdef REG_DUMP_CKSUM_EN
        cksum_d = cksum_q;
`endif
        // abort outranks every transition, including start in IDLE
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_d = ST_LOAD;
                        idx_d   = '0;
`ifdef REG_DUMP_CKSUM_EN
                        cksum_d = '0;
`endif
                    end
                end
                ST_LOAD: begin
                    shift_d = r_value;
                    bit_d   = '0;
                    state_d = ST_SHIFT;
`ifdef REG_DUMP_CKSUM_EN
                    cksum_d = cksum_q ^ r_value;
`endif
                end
                ST_SHIFT, ST_CKSHIFT: begin
                    if (bit_end) begin
                        shift_d = {shift_q[WORD_W-2:0], 1'b0};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == LAST_BIT) begin
                            if ((state_q == ST_SHIFT) && (idx_q != LAST_IDX)) begin
                                idx_d   = idx_q + 1'b1;
                                state_d = ST_LOAD;
                            end
`ifdef REG_DUMP_CKSUM_EN
                            else if (state_q == ST_SHIFT) begin
                                state_d = ST_CKLOAD;
                            end
`endif
                            else begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
`ifdef REG_DUMP_CKSUM_EN
                ST_CKLOAD: begin
                    shift_d = cksum_q;
                    bit_d   = '0;
                    state_d = ST_CKSHIFT;
                end
`endif
                ST_DONE: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            bit_q   <= '0;
`ifdef REG_DUMP_CKSUM_EN
            cksum_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
`ifdef REG_DUMP_CKSUM_EN
            cksum_q <= cksum_d;
`endif
        end
    end

    assign r_sel     = idx_q;
    assign sdo_valid = shifting;
    assign sdo       = shifting && shift_q[WORD_W-1];
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_reg_dump.sv
// Scoreboard bench for reg_dump: a fast instance (CLK_DIV=1, 16 regs) and a slow one (CLK_DIV=4, 2 regs).
// Expected words/done pulses, with their cycle stamps, are queued by stimulus and popped by a negedge monitor.
module tb_reg_dump;

`ifdef REG_DUMP_CKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int W1 = 33;   // 1 + 32*1
    localparam int W4 = 129;  // 1 + 32*4

    typedef struct {
        int          kind;    // 0 word, 1 done
        int          inst;
        logic [31:0] val;
        int          cyc;
        int          vcnt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start1, abort1, start4, abort4;
    logic [3:0]  r_sel1, r_sel4;
    logic [31:0] r_value1, r_value4;
    logic        sdo1, valid1, stb1, busy1, done1;
    logic        sdo4, valid4, stb4, busy4, done4;
    logic [31:0] rf1 [16];
    logic [31:0] rf4 [16];

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    logic [31:0] sh    [2];
    int          bits  [2];
    int          vcnt  [2];
    int          first [2];

    assign r_value1 = rf1[r_sel1];
    assign r_value4 = rf4[r_sel4];

    reg_dump #(.REG_COUNT(16), .CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .r_sel(r_sel1), .r_value(r_value1), .sdo(sdo1), .sdo_valid(valid1),
        .sdo_stb(stb1), .busy(busy1), .done(done1)
    );

    reg_dump #(.REG_COUNT(2), .CLK_DIV(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
        .r_sel(r_sel4), .r_value(r_value4), .sdo(sdo4), .sdo_valid(valid4),
        .sdo_stb(stb4), .busy(busy4), .done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push_word(input int inst, input logic [31:0] val, input int c, input int vc);
        exp_t x;
        x.kind = 0; x.inst = inst; x.val = val; x.cyc = c; x.vcnt = vc;
        exp_q.push_back(x);
    endtask

    task automatic push_done(input int inst, input int c);
        exp_t x;
        x.kind = 1; x.inst = inst; x.val = '0; x.cyc = c; x.vcnt = 0;
        exp_q.push_back(x);
    endtask

    task automatic finish_word(input int n);
        exp_t x;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL word_unexpected: inst %0d got %h at cycle %0d, required nothing", n, sh[n], first[n]);
        end else begin
            x = exp_q.pop_front();
            if (x.kind != 0 || x.inst != n || x.val !== sh[n] || x.cyc != first[n] || x.vcnt != vcnt[n]) begin
                n_err++;
                $display("FAIL word: got inst %0d val %h cyc %0d valid_cycles %0d, required kind %0d inst %0d val %h cyc %0d valid_cycles %0d",
                         n, sh[n], first[n], vcnt[n], x.kind, x.inst, x.val, x.cyc, x.vcnt);
            end
        end
    endtask

    task automatic finish_done(input int n);
        exp_t x;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL done_unexpected: inst %0d done at cycle %0d, required nothing", n, cyc);
        end else begin
            x = exp_q.pop_front();
            if (x.kind != 1 || x.inst != n || x.cyc != cyc) begin
                n_err++;
                $display("FAIL done: got inst %0d cyc %0d, required kind %0d inst %0d cyc %0d",
                         n, cyc, x.kind, x.inst, x.cyc);
            end
        end
    endtask

    // Deserialises one instance: a word closes when the 32nd bit's hold ends
    task automatic mon_step(input int n, input logic v, input logic s, input logic d, input logic dn);
        if (bits[n] == 32 && (!v || s)) begin
            finish_word(n);
            bits[n] = 0;
            vcnt[n] = 0;
        end
        if (!v) begin
            bits[n] = 0;
            vcnt[n] = 0;
        end else begin
            if (s) begin
                if (bits[n] == 0) first[n] = cyc;
                sh[n] = {sh[n][30:0], d};
                bits[n]++;
            end
            vcnt[n]++;
        end
        if (dn) finish_done(n);
    endtask

    always @(negedge clk) begin
        mon_step(0, valid1, stb1, sdo1, done1);
        mon_step(1, valid4, stb4, sdo4, done4);
    end

    task automatic start_dut(input int n, output int e);
        @(negedge clk);
        if (n == 0) start1 = 1'b1; else start4 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
        e = cyc;
    endtask

    task automatic drain(input string name, input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic expect_full_dump1(input int e);
        logic [31:0] ck;
        ck = '0;
        for (int k = 0; k < 16; k++) begin
            push_word(0, rf1[k], e + 1 + W1 * k, 32);
            ck ^= rf1[k];
        end
        if (CK == 1) push_word(0, ck, e + 1 + W1 * 16, 32);
        push_done(0, e + W1 * (16 + CK));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        logic [31:0] ck;
        rst_n = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; start4 = 1'b0; abort4 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rf1[i] = '0;
            rf4[i] = '0;
        end
        for (int n = 0; n < 2; n++) begin
            sh[n] = '0; bits[n] = 0; vcnt[n] = 0; first[n] = 0;
        end
        repeat (3) @(negedge clk);
        check("reset_outputs_1", 32'({r_sel1, sdo1, valid1, stb1, busy1, done1}), 32'd0);
        check("reset_outputs_4", 32'({r_sel4, sdo4, valid4, stb4, busy4, done4}), 32'd0);
        rst_n = 1'b1;

        // Full dump, CLK_DIV=1, reg i = 0x1000_0000+i (reg0 = 0)
        for (int i = 1; i < 16; i++) rf1[i] = 32'h1000_0000 + 32'(i);
        start_dut(0, e);
        expect_full_dump1(e);
        check("a_load_cycle", 32'({busy1, r_sel1, valid1}), 32'h20);
        @(negedge clk);
        check("a_first_bit_stb", 32'({valid1, stb1}), 32'h3);
        repeat (W1 * (16 + CK) - 1) @(negedge clk);
        check("a_busy_at_done", 32'(busy1), 32'd1);
        @(negedge clk);
        check("a_busy_after_done", 32'(busy1), 32'd0);
        drain("a_drain", 10);

        // reg i = i*0x0101_0101, reg5 rewritten during word 3
        for (int i = 0; i < 16; i++) rf1[i] = 32'h0101_0101 * 32'(i);
        start_dut(0, e);
        ck = '0;
        for (int k = 0; k < 16; k++) begin
            logic [31:0] v;
            v = (k == 5) ? 32'hDEAD_BEEF : rf1[k];
            push_word(0, v, e + 1 + W1 * k, 32);
            ck ^= v;
        end
        if (CK == 1) push_word(0, ck, e + 1 + W1 * 16, 32);
        push_done(0, e + W1 * (16 + CK));
        repeat (1 + W1 * 3 + 10) @(negedge clk);
        rf1[5] = 32'hDEAD_BEEF;
        drain("b_drain", 2000);

        // start during SHIFT is ignored; abort mid-word 7 ends the dump with no done
        for (int i = 0; i < 16; i++) rf1[i] = 32'h1000_0000 + 32'(i);
        start_dut(0, e);
        for (int k = 0; k < 7; k++) push_word(0, rf1[k], e + 1 + W1 * k, 32);
        repeat (1 + W1 * 2 + 5) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat ((1 + W1 * 7 + 10) - (2 + W1 * 2 + 5)) @(negedge clk);
        check("c_busy_before_abort", 32'({busy1, valid1, r_sel1}), 32'h37);
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        check("c_after_abort", 32'({busy1, valid1, r_sel1, done1}), 32'd0);
        repeat (700) @(negedge clk);
        check("c_no_more_output", 32'(exp_q.size()), 32'd0);
        start1 = 1'b1;
        abort1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        abort1 = 1'b0;
        check("c_start_abort_idle", 32'(busy1), 32'd0);

        // Asynchronous reset mid-bit, then a fresh dump from reg0
        start_dut(0, e);
        push_word(0, rf1[0], e + 1, 32);
        push_word(0, rf1[1], e + 1 + W1, 32);
        repeat (1 + W1 * 2 + 5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("d_async_reset", 32'({r_sel1, sdo1, valid1, stb1, busy1, done1}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drain("d_partial_drain", 10);
        for (int i = 0; i < 16; i++) rf1[i] = ~(32'h0F0F_0000 + 32'(i));
        start_dut(0, e);
        expect_full_dump1(e);
        drain("d_fresh_drain", 2000);

        // CLK_DIV=4: bits held four cycles, one strobe each, first bit two cycles after start
        rf4[0] = 32'hA5A5_A5A5;
        rf4[1] = 32'h8000_0001;
        start_dut(1, e);
        push_word(1, rf4[0], e + 1, 128);
        push_word(1, rf4[1], e + 1 + W4, 128);
        if (CK == 1) push_word(1, rf4[0] ^ rf4[1], e + 1 + W4 * 2, 128);
        push_done(1, e + W4 * (2 + CK));
        check("e_load_cycle", 32'({busy4, valid4}), 32'h2);
        @(negedge clk);
        check("e_bit0_first", 32'({valid4, stb4, sdo4}), 32'h7);
        @(negedge clk);
        check("e_bit0_held", 32'({valid4, stb4, sdo4}), 32'h5);
        repeat (3) @(negedge clk);
        check("e_bit1_first", 32'({valid4, stb4, sdo4}), 32'h6);
        drain("e_drain", 1000);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
